// File: rtl/wb_stream_reader_dma.sv
// wb_stream_reader_dma
//   Stream-to-memory DMA. A valid/ready stream fills an internal FIFO at any
//   time. Once started, the engine writes the FIFO contents to a memory buffer
//   using Wishbone incrementing bursts, each burst no longer than what the
//   FIFO already holds.
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   wbm_*             Wishbone burst master (write only, wbm_dat_i unused)
//   stream_s_*        input stream, ready = FIFO not full
//   irq_o             level interrupt, follows the irq pending bit
//   wbs_*             Wishbone config slave. Word registers at adr[4:2]:
//                     0 CTRL  wr: bit0 start, bit1 clear irq
//                             rd: {err, irq, busy}
//                     1 START_ADR  2 BUF_SIZE  3 BURST_SIZE  4 TX_CNT (ro)
module wb_stream_reader_dma #(
  parameter int WB_DW         = 32,
  parameter int WB_AW         = 32,
  parameter int FIFO_AW       = 4,
  parameter int MAX_BURST_LEN = 2**FIFO_AW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // burst master
  output logic [WB_AW-1:0]     wbm_adr_o,
  output logic [WB_DW-1:0]     wbm_dat_o,
  output logic [WB_DW/8-1:0]   wbm_sel_o,
  output logic                 wbm_we_o,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic [2:0]           wbm_cti_o,
  output logic [1:0]           wbm_bte_o,
  input  logic [WB_DW-1:0]     wbm_dat_i,
  input  logic                 wbm_ack_i,
  input  logic                 wbm_err_i,
  input  logic                 wbm_rty_i,
  // stream sink
  input  logic [WB_DW-1:0]     stream_s_data_i,
  input  logic                 stream_s_valid_i,
  output logic                 stream_s_ready_o,
  output logic                 irq_o,
  // config slave
  input  logic [WB_AW-1:0]     wbs_adr_i,
  input  logic [WB_DW-1:0]     wbs_dat_i,
  input  logic [WB_DW/8-1:0]   wbs_sel_i,
  input  logic                 wbs_we_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic [2:0]           wbs_cti_i,
  input  logic [1:0]           wbs_bte_i,
  output logic [WB_DW-1:0]     wbs_dat_o,
  output logic                 wbs_ack_o,
  output logic                 wbs_err_o,
  output logic                 wbs_rty_o
);

  localparam int NB    = WB_DW/8;
  localparam int DEPTH = 2**FIFO_AW;
  localparam int BSH   = $clog2(NB);
  localparam logic [WB_DW-1:0] MAX_LEN = WB_DW'(MAX_BURST_LEN);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_BURST} state_t;
  state_t state_q, state_d;

  // FIFO
  logic [WB_DW-1:0]   fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   fifo_cnt;
  logic               full, push, pop;

  // registers
  logic [WB_AW-1:0] start_adr;
  logic [WB_DW-1:0] buf_size, burst_size, tx_cnt, beats_left;
  logic             irq_q, err_q;

  logic [2:0]       reg_idx;
  logic             cfg_acc, cfg_wr, start_req, irq_clr, busy;
  logic [WB_DW-1:0] remaining, burst_len, rd_data, tx_cnt_inc;
  logic             fifo_ok, last_beat, load_beats, done_set, err_set;

  logic unused_ok;
  assign unused_ok = ^{wbm_dat_i, wbm_rty_i, wbs_cti_i, wbs_bte_i, wbs_adr_i};

  function automatic logic [WB_DW-1:0] wmerge(input logic [WB_DW-1:0] cur,
                                              input logic [WB_DW-1:0] wd,
                                              input logic [NB-1:0]    sel);
    wmerge = cur;
    for (int b = 0; b < NB; b++)
      if (sel[b]) wmerge[b*8 +: 8] = wd[b*8 +: 8];
  endfunction

  // ---------------- config decode ----------------
  assign reg_idx   = wbs_adr_i[4:2];
  assign cfg_acc   = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign cfg_wr    = cfg_acc & wbs_we_i;
  assign busy      = (state_q != ST_IDLE);
  assign start_req = cfg_wr && reg_idx == 3'd0 && wbs_sel_i[0] && wbs_dat_i[0] && !busy;
  assign irq_clr   = cfg_wr && reg_idx == 3'd0 && wbs_sel_i[0] && wbs_dat_i[1];

  // ---------------- FIFO ----------------
  assign full             = fifo_cnt[FIFO_AW];
  // held low while reset is asserted so nothing is accepted into a flushing FIFO
  assign stream_s_ready_o = rst_n & ~full;
  assign push             = stream_s_valid_i & stream_s_ready_o;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= stream_s_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (FIFO_AW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (FIFO_AW+1)'(1);
        default: ;
      endcase
    end
  end

  // ---------------- burst sizing ----------------
  // Length is clamped to what is left of the buffer, so WAIT never needs
  // more words than the transfer still owes.
  always_comb begin
    remaining = buf_size - tx_cnt;
    burst_len = (burst_size == '0) ? WB_DW'(1) : burst_size;
    if (burst_len > MAX_LEN)   burst_len = MAX_LEN;
    if (burst_len > remaining) burst_len = remaining;
  end

  assign fifo_ok    = WB_DW'(fifo_cnt) >= burst_len;
  assign last_beat  = (beats_left == WB_DW'(1));
  assign tx_cnt_inc = tx_cnt + WB_DW'(1);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    load_beats = 1'b0;
    pop        = 1'b0;
    done_set   = 1'b0;
    err_set    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          if (buf_size == '0) done_set = 1'b1;
          else                state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (fifo_ok) begin
          state_d    = ST_BURST;
          load_beats = 1'b1;
        end
      end
      ST_BURST: begin
        // rty simply holds the current beat: no pop, no address advance
        if (wbm_err_i) begin
          err_set = 1'b1;
          state_d = ST_IDLE;
        end else if (wbm_ack_i) begin
          pop = 1'b1;
          if (last_beat) begin
            if (tx_cnt_inc == buf_size) begin
              state_d  = ST_IDLE;
              done_set = 1'b1;
            end else begin
              state_d  = ST_WAIT;  // guarantees cyc low for a cycle
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_adr  <= '0;
      buf_size   <= '0;
      burst_size <= '0;
      tx_cnt     <= '0;
      beats_left <= '0;
      irq_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (start_req) begin
        tx_cnt <= '0;
        err_q  <= 1'b0;
      end else if (pop) begin
        tx_cnt <= tx_cnt_inc;
      end

      if (load_beats) beats_left <= burst_len;
      else if (pop)   beats_left <= beats_left - WB_DW'(1);

      // set after clear: a completion in the same cycle wins
      if (irq_clr)             irq_q <= 1'b0;
      if (done_set || err_set) irq_q <= 1'b1;
      if (err_set)             err_q <= 1'b1;

      if (cfg_wr && !busy) begin
        case (reg_idx)
          3'd1: start_adr  <= WB_AW'(wmerge(WB_DW'(start_adr), wbs_dat_i, wbs_sel_i));
          3'd2: buf_size   <= wmerge(buf_size, wbs_dat_i, wbs_sel_i);
          3'd3: burst_size <= wmerge(burst_size, wbs_dat_i, wbs_sel_i);
          default: ;
        endcase
      end
    end
  end

  // ---------------- config read / ack ----------------
  always_comb begin
    rd_data = '0;
    case (reg_idx)
      3'd0:    rd_data[2:0] = {err_q, irq_q, busy};
      3'd1:    rd_data = WB_DW'(start_adr);
      3'd2:    rd_data = buf_size;
      3'd3:    rd_data = burst_size;
      3'd4:    rd_data = tx_cnt;
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= cfg_acc;
      if (cfg_acc) wbs_dat_o <= rd_data;
    end
  end

  assign wbs_err_o = 1'b0;
  assign wbs_rty_o = 1'b0;
  assign irq_o     = irq_q;

  // ---------------- master outputs ----------------
  // Everything is derived from the registered state so cyc falls with reset.
  assign wbm_cyc_o = (state_q == ST_BURST);
  assign wbm_stb_o = wbm_cyc_o;
  assign wbm_we_o  = wbm_cyc_o;
  assign wbm_sel_o = wbm_cyc_o ? '1 : '0;
  assign wbm_adr_o = wbm_cyc_o ? start_adr + (WB_AW'(tx_cnt) << BSH) : '0;
  assign wbm_dat_o = wbm_cyc_o ? fifo_mem[rd_ptr] : '0;
  assign wbm_cti_o = wbm_cyc_o ? (last_beat ? 3'b111 : 3'b010) : 3'b000;
  assign wbm_bte_o = 2'b00;

endmodule

// File: tb/tb_wb_stream_reader_dma.sv
module tb_wb_stream_reader_dma;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack_i = 1'b0, wbm_err_i = 1'b0, wbm_rty_i = 1'b0;
  logic [31:0] stream_s_data_i = '0;
  logic        stream_s_valid_i = 1'b0, stream_s_ready_o, irq_o;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0, wbs_dat_o;
  logic [3:0]  wbs_sel_i = '0;
  logic        wbs_we_i = 1'b0, wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0;
  logic [2:0]  wbs_cti_i = '0;
  logic [1:0]  wbs_bte_i = '0;
  logic        wbs_ack_o, wbs_err_o, wbs_rty_o;

  wb_stream_reader_dma dut (
    .clk(clk), .rst_n(rst_n),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
    .stream_s_data_i(stream_s_data_i), .stream_s_valid_i(stream_s_valid_i),
    .stream_s_ready_o(stream_s_ready_o), .irq_o(irq_o),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
    .wbs_we_i(wbs_we_i), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
    .wbs_cti_i(wbs_cti_i), .wbs_bte_i(wbs_bte_i), .wbs_dat_o(wbs_dat_o),
    .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_rty_o(wbs_rty_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- memory-side slave model ----------------
  // Responds on the falling edge so the DUT samples a stable response.
  logic        stall = 1'b0;
  int          rty_at = -1, err_at = -1;
  int          bidx = 0, bursts = 0;
  logic        rty_done = 1'b0, cyc_prev = 1'b0, err_pend = 1'b0;
  logic        err_cyc_after = 1'b1;
  logic [31:0] rty_adr = '0, rty_dat = '0;
  logic [31:0] adr_q[$], dat_q[$];
  logic [2:0]  cti_q[$];

  always @(negedge clk) begin
    wbm_ack_i <= 1'b0;
    wbm_err_i <= 1'b0;
    wbm_rty_i <= 1'b0;
    if (err_pend) begin
      err_cyc_after <= wbm_cyc_o;
      err_pend      <= 1'b0;
    end
    if (!wbm_cyc_o) begin
      bidx     <= 0;
      rty_done <= 1'b0;
    end else begin
      if (!cyc_prev) bursts <= bursts + 1;
      if (stall) begin
      end else if (bidx == err_at) begin
        wbm_err_i <= 1'b1;
        err_pend  <= 1'b1;
      end else if (bidx == rty_at && !rty_done) begin
        wbm_rty_i <= 1'b1;
        rty_done  <= 1'b1;
        rty_adr   <= wbm_adr_o;
        rty_dat   <= wbm_dat_o;
      end else begin
        wbm_ack_i <= 1'b1;
        adr_q.push_back(wbm_adr_o);
        dat_q.push_back(wbm_dat_o);
        cti_q.push_back(wbm_cti_o);
        bidx <= bidx + 1;
      end
    end
    cyc_prev <= wbm_cyc_o;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wb_access(input logic [31:0] a, input logic [31:0] d, input logic we,
                           output logic [31:0] rd);
    int n = 0;
    @(negedge clk);
    wbs_adr_i = a; wbs_dat_i = d; wbs_we_i = we; wbs_sel_i = 4'hf;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    do begin
      @(posedge clk); #1; n++;
    end while (!wbs_ack_o && n < 10);
    if (!wbs_ack_o) chk("wbs_ack_timeout", {31'd0, wbs_ack_o}, 32'd1);
    rd = wbs_dat_o;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb_access(a, d, 1'b1, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    wb_access(a, 32'd0, 1'b0, v);
    chk(tag, v, exp);
  endtask

  task automatic push(input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    while (!stream_s_ready_o && n < 100) begin @(negedge clk); n++; end
    stream_s_data_i = d; stream_s_valid_i = 1'b1;
    @(posedge clk); #1;
    stream_s_valid_i = 1'b0;
  endtask

  task automatic wait_irq(input string tag);
    int n = 0;
    while (!irq_o && n < 300) begin @(negedge clk); n++; end
    if (!irq_o) chk(tag, {31'd0, irq_o}, 32'd1);
  endtask

  task automatic setup(input logic [31:0] sa, input logic [31:0] bs, input logic [31:0] bu);
    wb_write(32'h4, sa);
    wb_write(32'h8, bs);
    wb_write(32'hC, bu);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base, b0, acc, n;
    logic rdy;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ready_low", {31'd0, stream_s_ready_o}, 32'd0);
    chk("rst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    chk("rst_irq", {31'd0, irq_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready_high", {31'd0, stream_s_ready_o}, 32'd1);
    rd_chk("rst_ctrl", 32'h0, 32'd0);
    rd_chk("rst_txcnt", 32'h10, 32'd0);

    // 1: BUF=8 BURST=4, two 4-beat bursts
    base = adr_q.size(); b0 = bursts;
    setup(32'h1000, 32'd8, 32'd4);
    for (int i = 0; i < 8; i++) push(32'(i));
    wb_write(32'h0, 32'h1);
    wait_irq("t1_irq_timeout");
    @(negedge clk);
    chk("t1_beats", 32'(adr_q.size() - base), 32'd8);
    for (int i = 0; i < 8 && base + i < adr_q.size(); i++) begin
      chk("t1_adr", adr_q[base+i], 32'h1000 + 32'(4*i));
      chk("t1_dat", dat_q[base+i], 32'(i));
      chk("t1_cti", {29'd0, cti_q[base+i]}, (i % 4 == 3) ? 32'd7 : 32'd2);
    end
    chk("t1_bursts", 32'(bursts - b0), 32'd2);
    rd_chk("t1_txcnt", 32'h10, 32'd8);
    rd_chk("t1_ctrl", 32'h0, 32'b010);
    wb_write(32'h0, 32'h2);
    chk("t1_irq_clr", {31'd0, irq_o}, 32'd0);

    // 2: BUF=5 BURST=4 -> 4 + single beat
    base = adr_q.size(); b0 = bursts;
    setup(32'h2000, 32'd5, 32'd4);
    for (int i = 0; i < 5; i++) push(32'h20 + 32'(i));
    wb_write(32'h0, 32'h1);
    wait_irq("t2_irq_timeout");
    @(negedge clk);
    chk("t2_beats", 32'(adr_q.size() - base), 32'd5);
    if (adr_q.size() >= base + 5) begin
      chk("t2_cti3", {29'd0, cti_q[base+3]}, 32'd7);
      chk("t2_cti0", {29'd0, cti_q[base]}, 32'd2);
      chk("t2_last_adr", adr_q[base+4], 32'h2010);
      chk("t2_last_cti", {29'd0, cti_q[base+4]}, 32'd7);
      chk("t2_last_dat", dat_q[base+4], 32'h24);
    end
    chk("t2_bursts", 32'(bursts - b0), 32'd2);
    wb_write(32'h0, 32'h2);

    // 3: stalled slave, stream held valid -> FIFO fills to 16
    base = adr_q.size();
    stall = 1'b1;
    setup(32'h3000, 32'd16, 32'd16);
    wb_write(32'h0, 32'h1);
    rd_chk("t3_busy", 32'h0, 32'b001);
    acc = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      stream_s_data_i = 32'h100 + 32'(acc); stream_s_valid_i = 1'b1;
      rdy = stream_s_ready_o;
      @(posedge clk);
      if (rdy) acc++;
    end
    @(negedge clk);
    stream_s_valid_i = 1'b0;
    chk("t3_accepted", 32'(acc), 32'd16);
    chk("t3_ready_low", {31'd0, stream_s_ready_o}, 32'd0);
    chk("t3_cyc_stalled", {31'd0, wbm_cyc_o}, 32'd1);
    wb_write(32'h8, 32'd99);
    stall = 1'b0;
    wait_irq("t3_irq_timeout");
    @(negedge clk);
    chk("t3_beats", 32'(adr_q.size() - base), 32'd16);
    for (int i = 0; i < 16 && base + i < adr_q.size(); i++) begin
      chk("t3_dat", dat_q[base+i], 32'h100 + 32'(i));
      chk("t3_adr", adr_q[base+i], 32'h3000 + 32'(4*i));
    end
    rd_chk("t3_buf_locked", 32'h8, 32'd16);
    wb_write(32'h0, 32'h2);

    // 4: rty on beat 2 then ack
    base = adr_q.size(); b0 = bursts;
    rty_at = 2;
    setup(32'h4000, 32'd4, 32'd4);
    for (int i = 0; i < 4; i++) push(32'h40 + 32'(i));
    wb_write(32'h0, 32'h1);
    wait_irq("t4_irq_timeout");
    @(negedge clk);
    rty_at = -1;
    chk("t4_rty_adr", rty_adr, 32'h4008);
    chk("t4_rty_dat", rty_dat, 32'h42);
    chk("t4_beats", 32'(adr_q.size() - base), 32'd4);
    for (int i = 0; i < 4 && base + i < adr_q.size(); i++) begin
      chk("t4_adr", adr_q[base+i], 32'h4000 + 32'(4*i));
      chk("t4_dat", dat_q[base+i], 32'h40 + 32'(i));
    end
    chk("t4_bursts", 32'(bursts - b0), 32'd1);
    wb_write(32'h0, 32'h2);

    // 5: err on beat 1
    err_at = 1;
    setup(32'h5000, 32'd4, 32'd4);
    for (int i = 0; i < 4; i++) push(32'h50 + 32'(i));
    wb_write(32'h0, 32'h1);
    wait_irq("t5_irq_timeout");
    @(negedge clk);
    err_at = -1;
    chk("t5_cyc_dropped", {31'd0, err_cyc_after}, 32'd0);
    rd_chk("t5_ctrl", 32'h0, 32'b110);
    rd_chk("t5_txcnt", 32'h10, 32'd1);
    wb_write(32'h0, 32'h2);
    chk("t5_irq_clr", {31'd0, irq_o}, 32'd0);

    // 6: BUF=0 start, then reset mid-burst
    b0 = bursts;
    wb_write(32'h8, 32'd0);
    wb_write(32'h0, 32'h1);
    chk("t6_irq_next", {31'd0, irq_o}, 32'd1);
    chk("t6_no_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    repeat (3) @(negedge clk);
    chk("t6_no_burst", 32'(bursts - b0), 32'd0);
    wb_write(32'h0, 32'h2);
    stall = 1'b1;
    setup(32'h6000, 32'd4, 32'd4);
    wb_write(32'h0, 32'h1);
    push(32'h60);  // three words remain from the aborted transfer
    n = 0;
    while (!wbm_cyc_o && n < 20) begin @(negedge clk); n++; end
    chk("t6_cyc_up", {31'd0, wbm_cyc_o}, 32'd1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    chk("t6_rst_ready", {31'd0, stream_s_ready_o}, 32'd0);
    stall = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd_chk("t6_ctrl0", 32'h0, 32'd0);
    rd_chk("t6_start0", 32'h4, 32'd0);
    rd_chk("t6_buf0", 32'h8, 32'd0);
    rd_chk("t6_burst0", 32'hC, 32'd0);
    rd_chk("t6_tx0", 32'h10, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
